alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

ID/EX pipeline stage that decodes a MIPS instruction into the ALU's `ALUCtrl` code and registered operand buses for the following EX-stage ALU. It selects the operands (register, shamt, or extended immediate) and applies EX/MEM and MEM/WB forwarding at capture time. It also handles stall and flush for the pipelined datapath.

## Interface
- No parameters; all widths fixed (32-bit data, 5-bit register numbers, 4-bit `ALUCtrl`).
- `Clk` — input, 1 — rising-edge clock.
- `Reset` — input, 1 — asynchronous, active-high.
- `Instruction` — input, 32 — IF/ID instruction word.
- `InValid` — input, 1 — `Instruction` is a real instruction, not a bubble.
- `RsData`, `RtData` — input, 32 each — register-file read data for rs and rt.
- `ExMemRegWrite`, `ExMemRw`, `ExMemData` — input, 1/5/32 — EX/MEM forwarding source.
- `MemWbRegWrite`, `MemWbRw`, `MemWbData` — input, 1/5/32 — MEM/WB forwarding source.
- `Stall` — input, 1 — hold all registered outputs.
- `Flush` — input, 1 — load a bubble.
- `BusA`, `BusB` — output, 32 each — registered ALU operands.
- `ALUCtrl` — output, 4 — registered ALU operation code.
- `Rw` — output, 5 — registered destination register.
- `RegWrite` — output, 1 — registered write enable.
- `Valid` — output, 1 — registered: the EX stage holds a real instruction.
- `Illegal` — output, 1 — registered: the captured instruction had an unsupported opcode or funct.

## Operation
- **ALUCtrl codes:**
  - AND=0000, OR=0001, ADD=0010, SLL=0011, SRL=0100, SUB=0110, SLT=0111.
  - ADDU=1000, SUBU=1001, XOR=1010, SLTU=1011, NOR=1100, SRA=1101, LUI=1110.
- **Fields:** op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
- **Operand forwarding:**
  - `fwdA` = rs value, `fwdB` = rt value.
  - For each, use `ExMemData` if `ExMemRegWrite` and `ExMemRw` equals the register and the register is nonzero.
  - Otherwise use `MemWbData` under the same conditions with the MEM/WB signals.
  - Otherwise use the register-file data.
  - EX/MEM always beats MEM/WB. Register $0 is never forwarded.
- **R-type (op=0x00):** `Rw`=rd, `RegWrite`=1 (except jr below), `BusA`=`fwdA`, `BusB`=`fwdB`.
  - funct 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU.
  - funct 0x00 SLL, 0x02 SRL, 0x03 SRA: `BusA`={27'b0, shamt}.
  - funct 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: same codes as SLL/SRL/SRA; `BusA`={27'b0, `fwdA`[4:0]}.
  - funct 0x08 jr: ALUCtrl=ADD, `RegWrite`=0.
- **I-type:** `Rw`=rt, `BusA`=`fwdA`.
  - 0x08 ADD, 0x09 ADDU, 0x0A SLT, 0x0B SLTU: `BusB` = sign-extended imm.
  - 0x0C AND, 0x0D OR, 0x0E XOR: `BusB` = zero-extended imm.
  - 0x0F LUI: `BusB` = zero-extended imm; ALU shifts it by 16.
  - 0x23 lw: ADD with sign-extended imm, `RegWrite`=1.
  - 0x2B sw: ADD with sign-extended imm, `RegWrite`=0.
  - 0x04 beq, 0x05 bne: SUB with `BusB`=`fwdB`, `RegWrite`=0.
  - All other I-type opcodes listed here: `RegWrite`=1.
- **Unsupported op or funct:** `Illegal`=1, `RegWrite`=0, ALUCtrl=AND, `Valid`=`InValid`.
- **InValid=0:** capture a bubble.

## Timing
- Latency is 1 cycle: an instruction presented in cycle N appears on the outputs after edge N+1.
- Forwarding inputs are sampled at the same edge as the instruction.
- **Bubble:** all outputs 0 (`BusA`, `BusB`, `ALUCtrl`, `Rw`, `RegWrite`, `Valid`, `Illegal`).
- **Reset:** asynchronous, forces a bubble immediately, independent of `Clk`. Deasserting mid-stream resumes capture at the next edge.
- **Priority:** `Reset` > `Flush` > `Stall` > normal capture. `Flush` with `Stall` produces a bubble.
- **Stall:** outputs hold bit-exact for every stalled cycle. No forwarding re-evaluation happens while stalled; the upstream hazard unit re-presents the instruction.
- **No combinational paths** from any input to any output.

## Test plan
- **Reset and add:** assert `Reset` mid-cycle → all outputs 0 immediately. Then `add $3,$1,$2` with `RsData`=5, `RtData`=7 → next cycle `BusA`=5, `BusB`=7, `ALUCtrl`=0010, `Rw`=3, `RegWrite`=1, `Valid`=1.
- **Shifts:** `sra $4,$5,3` (`RtData`=0x80000000) → `BusA`=3, `BusB`=0x80000000, `ALUCtrl`=1101. `srlv` with `RsData`=0x25 → `BusA`=5, `ALUCtrl`=0100.
- **Immediate extension:** `addi` imm=0xFFFF → `BusB`=0xFFFFFFFF, `ALUCtrl`=0010. `ori` imm=0xFFFF → `BusB`=0x0000FFFF, `ALUCtrl`=0001. `lui` imm=0x1234 → `BusB`=0x00001234, `ALUCtrl`=1110.
- **Forwarding:** rs=rt=$8 with EX/MEM (Rw=8, data 0xAA) and MEM/WB (Rw=8, data 0xBB) → `BusA`=`BusB`=0xAA. Drop EX/MEM → 0xBB. Set rs=$0 with both sources matching $0 → `RsData` used.
- **Stall/flush:** valid `sub` captured, then `Stall`=1 for 3 cycles with changing `Instruction` → outputs unchanged. Then `Flush`+`Stall` → bubble (all 0).
- **Illegal instruction:** op=0x3F with `InValid`=1 → `Illegal`=1, `Valid`=1, `RegWrite`=0, `ALUCtrl`=0000.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// ID/EX boundary bundle: decode-side instruction, register data and forwarding sources in, EX operands out.
// The upstream pipeline is the master; the issue stage is the slave.
interface alu_issue_stage_if;
    logic [31:0] Instruction;
    logic        InValid;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        ExMemRegWrite;
    logic [4:0]  ExMemRw;
    logic [31:0] ExMemData;
    logic        MemWbRegWrite;
    logic [4:0]  MemWbRw;
    logic [31:0] MemWbData;
    logic        Stall;
    logic        Flush;
    logic [31:0] BusA;
    logic [31:0] BusB;
    logic [3:0]  ALUCtrl;
    logic [4:0]  Rw;
    logic        RegWrite;
    logic        Valid;
    logic        Illegal;

    modport master (
        output Instruction, InValid, RsData, RtData,
        output ExMemRegWrite, ExMemRw, ExMemData,
        output MemWbRegWrite, MemWbRw, MemWbData,
        output Stall, Flush,
        input  BusA, BusB, ALUCtrl, Rw, RegWrite, Valid, Illegal
    );

    modport slave (
        input  Instruction, InValid, RsData, RtData,
        input  ExMemRegWrite, ExMemRw, ExMemData,
        input  MemWbRegWrite, MemWbRw, MemWbData,
        input  Stall, Flush,
        output BusA, BusB, ALUCtrl, Rw, RegWrite, Valid, Illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// MIPS ID/EX stage: decodes to ALUCtrl, selects and forwards operands into registered EX buses.
// Latency 1 cycle; all outputs registered, no input-to-output combinational path.
// Stall holds outputs bit-exact; Flush (beats Stall) and Reset load a bubble.
module alu_issue_stage (
    input  logic           Clk,
    input  logic           Reset,
    alu_issue_stage_if.slave bus
);
    localparam logic [3:0] C_AND  = 4'b0000, C_OR   = 4'b0001, C_ADD  = 4'b0010,
                           C_SLL  = 4'b0011, C_SRL  = 4'b0100, C_SUB  = 4'b0110,
                           C_SLT  = 4'b0111, C_ADDU = 4'b1000, C_SUBU = 4'b1001,
                           C_XOR  = 4'b1010, C_SLTU = 4'b1011, C_NOR  = 4'b1100,
                           C_SRA  = 4'b1101, C_LUI  = 4'b1110;

    typedef struct packed {
        logic [31:0] bus_a;
        logic [31:0] bus_b;
        logic [3:0]  alu_ctrl;
        logic [4:0]  rw;
        logic        reg_write;
        logic        valid;
        logic        illegal;
    } ex_t;

    ex_t ex_q;
    ex_t ex_nxt;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] sext_imm, zext_imm, fwd_a, fwd_b;

    assign op       = bus.Instruction[31:26];
    assign rs       = bus.Instruction[25:21];
    assign rt       = bus.Instruction[20:16];
    assign rd       = bus.Instruction[15:11];
    assign shamt    = bus.Instruction[10:6];
    assign funct    = bus.Instruction[5:0];
    assign sext_imm = {{16{bus.Instruction[15]}}, bus.Instruction[15:0]};
    assign zext_imm = {16'b0, bus.Instruction[15:0]};

    // EX/MEM is the younger result, so it wins over MEM/WB; $0 is hardwired and never forwarded.
    function automatic logic [31:0] fwd(
        input logic [4:0]  r,
        input logic [31:0] rf,
        input logic        em_we,
        input logic [4:0]  em_rw,
        input logic [31:0] em_dat,
        input logic        mw_we,
        input logic [4:0]  mw_rw,
        input logic [31:0] mw_dat
    );
        if (em_we && em_rw == r && r != 5'd0)      fwd = em_dat;
        else if (mw_we && mw_rw == r && r != 5'd0) fwd = mw_dat;
        else                                       fwd = rf;
    endfunction

    assign fwd_a = fwd(rs, bus.RsData, bus.ExMemRegWrite, bus.ExMemRw, bus.ExMemData,
                       bus.MemWbRegWrite, bus.MemWbRw, bus.MemWbData);
    assign fwd_b = fwd(rt, bus.RtData, bus.ExMemRegWrite, bus.ExMemRw, bus.ExMemData,
                       bus.MemWbRegWrite, bus.MemWbRw, bus.MemWbData);

    always_comb begin
        ex_nxt = '0;
        if (bus.InValid) begin
            ex_nxt.valid = 1'b1;
            if (op == 6'h00) begin
                ex_nxt.rw        = rd;
                ex_nxt.reg_write = 1'b1;
                ex_nxt.bus_a     = fwd_a;
                ex_nxt.bus_b     = fwd_b;
                case (funct)
                    6'h20: ex_nxt.alu_ctrl = C_ADD;
                    6'h21: ex_nxt.alu_ctrl = C_ADDU;
                    6'h22: ex_nxt.alu_ctrl = C_SUB;
                    6'h23: ex_nxt.alu_ctrl = C_SUBU;
                    6'h24: ex_nxt.alu_ctrl = C_AND;
                    6'h25: ex_nxt.alu_ctrl = C_OR;
                    6'h26: ex_nxt.alu_ctrl = C_XOR;
                    6'h27: ex_nxt.alu_ctrl = C_NOR;
                    6'h2A: ex_nxt.alu_ctrl = C_SLT;
                    6'h2B: ex_nxt.alu_ctrl = C_SLTU;
                    6'h00: begin ex_nxt.alu_ctrl = C_SLL; ex_nxt.bus_a = {27'b0, shamt}; end
                    6'h02: begin ex_nxt.alu_ctrl = C_SRL; ex_nxt.bus_a = {27'b0, shamt}; end
                    6'h03: begin ex_nxt.alu_ctrl = C_SRA; ex_nxt.bus_a = {27'b0, shamt}; end
                    6'h04: begin ex_nxt.alu_ctrl = C_SLL; ex_nxt.bus_a = {27'b0, fwd_a[4:0]}; end
                    6'h06: begin ex_nxt.alu_ctrl = C_SRL; ex_nxt.bus_a = {27'b0, fwd_a[4:0]}; end
                    6'h07: begin ex_nxt.alu_ctrl = C_SRA; ex_nxt.bus_a = {27'b0, fwd_a[4:0]}; end
                    6'h08: begin ex_nxt.alu_ctrl = C_ADD; ex_nxt.reg_write = 1'b0; end
                    default: ex_nxt.illegal = 1'b1;
                endcase
            end else begin
                ex_nxt.rw        = rt;
                ex_nxt.reg_write = 1'b1;
                ex_nxt.bus_a     = fwd_a;
                case (op)
                    6'h08: begin ex_nxt.alu_ctrl = C_ADD;  ex_nxt.bus_b = sext_imm; end
                    6'h09: begin ex_nxt.alu_ctrl = C_ADDU; ex_nxt.bus_b = sext_imm; end
                    6'h0A: begin ex_nxt.alu_ctrl = C_SLT;  ex_nxt.bus_b = sext_imm; end
                    6'h0B: begin ex_nxt.alu_ctrl = C_SLTU; ex_nxt.bus_b = sext_imm; end
                    6'h0C: begin ex_nxt.alu_ctrl = C_AND;  ex_nxt.bus_b = zext_imm; end
                    6'h0D: begin ex_nxt.alu_ctrl = C_OR;   ex_nxt.bus_b = zext_imm; end
                    6'h0E: begin ex_nxt.alu_ctrl = C_XOR;  ex_nxt.bus_b = zext_imm; end
                    6'h0F: begin ex_nxt.alu_ctrl = C_LUI;  ex_nxt.bus_b = zext_imm; end
                    6'h23: begin ex_nxt.alu_ctrl = C_ADD;  ex_nxt.bus_b = sext_imm; end
                    6'h2B: begin
                        ex_nxt.alu_ctrl = C_ADD; ex_nxt.bus_b = sext_imm; ex_nxt.reg_write = 1'b0;
                    end
                    6'h04, 6'h05: begin
                        ex_nxt.alu_ctrl = C_SUB; ex_nxt.bus_b = fwd_b; ex_nxt.reg_write = 1'b0;
                    end
                    default: ex_nxt.illegal = 1'b1;
                endcase
            end
            // An illegal capture keeps Valid so the trap reaches EX, but carries no side effects.
            if (ex_nxt.illegal) begin
                ex_nxt.bus_a     = '0;
                ex_nxt.bus_b     = '0;
                ex_nxt.rw        = '0;
                ex_nxt.reg_write = 1'b0;
                ex_nxt.alu_ctrl  = C_AND;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)          ex_q <= '0;
        else if (bus.Flush) ex_q <= '0;
        else if (!bus.Stall) ex_q <= ex_nxt;
    end

    assign bus.BusA     = ex_q.bus_a;
    assign bus.BusB     = ex_q.bus_b;
    assign bus.ALUCtrl  = ex_q.alu_ctrl;
    assign bus.Rw       = ex_q.rw;
    assign bus.RegWrite = ex_q.reg_write;
    assign bus.Valid    = ex_q.valid;
    assign bus.Illegal  = ex_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;
    logic Clk;
    logic Reset;
    int   checks;
    int   failures;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] ctrl, input logic [4:0] rw,
                              input logic we, input logic vld, input logic ill);
        check({tag, ".BusA"},     bus.BusA,     a);
        check({tag, ".BusB"},     bus.BusB,     b);
        check({tag, ".ALUCtrl"},  {28'b0, bus.ALUCtrl}, {28'b0, ctrl});
        check({tag, ".Rw"},       {27'b0, bus.Rw},      {27'b0, rw});
        check({tag, ".RegWrite"}, {31'b0, bus.RegWrite}, {31'b0, we});
        check({tag, ".Valid"},    {31'b0, bus.Valid},    {31'b0, vld});
        check({tag, ".Illegal"},  {31'b0, bus.Illegal},  {31'b0, ill});
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        rtype = {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        itype = {op, rs, rt, imm};
    endfunction

    // Present an instruction before the next rising edge, then sample 1 time unit after it.
    task automatic issue(input logic [31:0] ins);
        @(negedge Clk);
        bus.Instruction = ins;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset = 1'b1;
        bus.Instruction   = '0;
        bus.InValid       = 1'b1;
        bus.RsData        = '0;
        bus.RtData        = '0;
        bus.ExMemRegWrite = 1'b0;
        bus.ExMemRw       = '0;
        bus.ExMemData     = '0;
        bus.MemWbRegWrite = 1'b0;
        bus.MemWbRw       = '0;
        bus.MemWbData     = '0;
        bus.Stall         = 1'b0;
        bus.Flush         = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        expect_out("reset", 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;

        // add $3,$1,$2
        bus.RsData = 32'd5;
        bus.RtData = 32'd7;
        issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        expect_out("add", 32'd5, 32'd7, 4'b0010, 5'd3, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset between edges clears outputs at once.
        #2 Reset = 1'b1;
        #1;
        expect_out("async_rst", 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        expect_out("add_after_rst", 32'd5, 32'd7, 4'b0010, 5'd3, 1'b1, 1'b1, 1'b0);

        // sra $4,$5,3
        bus.RtData = 32'h8000_0000;
        issue(rtype(5'd0, 5'd5, 5'd4, 5'd3, 6'h03));
        expect_out("sra", 32'd3, 32'h8000_0000, 4'b1101, 5'd4, 1'b1, 1'b1, 1'b0);

        // srlv $6,$7,$9
        bus.RsData = 32'h25;
        bus.RtData = 32'h1234_5678;
        issue(rtype(5'd9, 5'd7, 5'd6, 5'd0, 6'h06));
        expect_out("srlv", 32'd5, 32'h1234_5678, 4'b0100, 5'd6, 1'b1, 1'b1, 1'b0);

        // Immediates
        bus.RsData = 32'h0000_0010;
        issue(itype(6'h08, 5'd1, 5'd10, 16'hFFFF));
        expect_out("addi", 32'h10, 32'hFFFF_FFFF, 4'b0010, 5'd10, 1'b1, 1'b1, 1'b0);
        issue(itype(6'h0D, 5'd1, 5'd10, 16'hFFFF));
        expect_out("ori", 32'h10, 32'h0000_FFFF, 4'b0001, 5'd10, 1'b1, 1'b1, 1'b0);
        bus.RsData = 32'h0;
        issue(itype(6'h0F, 5'd0, 5'd11, 16'h1234));
        expect_out("lui", 32'h0, 32'h0000_1234, 4'b1110, 5'd11, 1'b1, 1'b1, 1'b0);
        bus.RsData = 32'h100;
        issue(itype(6'h2B, 5'd2, 5'd12, 16'h8004));
        expect_out("sw", 32'h100, 32'hFFFF_8004, 4'b0010, 5'd12, 1'b0, 1'b1, 1'b0);
        bus.RtData = 32'h77;
        issue(itype(6'h04, 5'd2, 5'd3, 16'h0010));
        expect_out("beq", 32'h100, 32'h77, 4'b0110, 5'd3, 1'b0, 1'b1, 1'b0);
        issue(rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
        expect_out("jr", 32'h100, 32'h77, 4'b0010, 5'd0, 1'b0, 1'b1, 1'b0);

        // Forwarding priority and $0 exclusion
        bus.RsData = 32'h11;
        bus.RtData = 32'h22;
        bus.ExMemRegWrite = 1'b1; bus.ExMemRw = 5'd8; bus.ExMemData = 32'hAA;
        bus.MemWbRegWrite = 1'b1; bus.MemWbRw = 5'd8; bus.MemWbData = 32'hBB;
        issue(rtype(5'd8, 5'd8, 5'd1, 5'd0, 6'h20));
        expect_out("fwd_exmem", 32'hAA, 32'hAA, 4'b0010, 5'd1, 1'b1, 1'b1, 1'b0);
        bus.ExMemRegWrite = 1'b0;
        issue(rtype(5'd8, 5'd8, 5'd1, 5'd0, 6'h20));
        expect_out("fwd_memwb", 32'hBB, 32'hBB, 4'b0010, 5'd1, 1'b1, 1'b1, 1'b0);
        bus.ExMemRegWrite = 1'b1; bus.ExMemRw = 5'd0;
        bus.MemWbRw = 5'd0;
        issue(rtype(5'd0, 5'd8, 5'd1, 5'd0, 6'h20));
        expect_out("fwd_zero", 32'h11, 32'h22, 4'b0010, 5'd1, 1'b1, 1'b1, 1'b0);
        bus.ExMemRegWrite = 1'b0;
        bus.MemWbRegWrite = 1'b0;

        // Stall holds, then Flush with Stall gives a bubble
        bus.RsData = 32'd100;
        bus.RtData = 32'd30;
        issue(rtype(5'd13, 5'd14, 5'd12, 5'd0, 6'h22));
        expect_out("sub", 32'd100, 32'd30, 4'b0110, 5'd12, 1'b1, 1'b1, 1'b0);
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.RsData = 32'hDEAD_0000 + i;
            issue(itype(6'h0D, 5'd3, 5'd20 + i[4:0], 16'h00F0 + i[15:0]));
            expect_out("stall", 32'd100, 32'd30, 4'b0110, 5'd12, 1'b1, 1'b1, 1'b0);
        end
        bus.Flush = 1'b1;
        issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        expect_out("flush_stall", 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        bus.Flush = 1'b0;
        bus.Stall = 1'b0;

        // Unsupported opcode and funct
        issue(itype(6'h3F, 5'd1, 5'd2, 16'h1234));
        expect_out("illegal_op", 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b1, 1'b1);
        issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F));
        expect_out("illegal_fn", 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b1, 1'b1);

        // InValid=0 captures a bubble even for a legal word
        bus.InValid = 1'b0;
        issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        expect_out("invalid", 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
